pixel_phase_tracker: RTL and testbench

Parametrised successor to the fixed x6 pixel-clock phase counter. Runs entirely in the PLL-multiplied system clock domain, where the system clock is RATIO × the incoming pixel clock. It samples the raw incoming pixel clock as data and aligns a divide-by-RATIO phase counter to its rising edges. It emits a one-cycle pixel enable at a runtime-selectable phase, with lock/loss-of-lock tracking and flywheel behaviour when edges are lost.

---
 rtl/pixel_phase_defs.sv | 34 +++
 rtl/bit_synchroniser.sv | 24 ++
 rtl/pixel_phase_tracker.sv | 136 +++++++++++++
 tb/tb_pixel_phase_tracker.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_phase_defs.sv
// Shared definitions for the pixel phase tracker: FSM encoding, clog2 and
// parameter legality checks used at elaboration.
package pixel_phase_defs;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } track_state_e;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  function automatic bit ratio_ok(input int ratio);
    return (ratio >= 3) && (ratio <= 16);
  endfunction

  function automatic bit sync_stages_ok(input int stages);
    return (stages >= 2) && (stages <= 4);
  endfunction

  function automatic bit lock_count_ok(input int count);
    return (count >= 1) && (count <= 255);
  endfunction

  function automatic bit loss_count_ok(input int count);
    return (count >= 1) && (count <= 15);
  endfunction

endpackage

// File: rtl/bit_synchroniser.sv
// Single-bit multi-flop synchroniser for an asynchronous level.
// Output lags the input by STAGES cycles; no backpressure.
module bit_synchroniser #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pixel_phase_tracker.sv
// Aligns a divide-by-RATIO phase counter to sampled pixel clock edges, with
// lock tracking, flywheel on lost edges and a phase-selectable pixel enable.
module pixel_phase_tracker
  import pixel_phase_defs::*;
#(
  parameter int RATIO       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 8,
  parameter int LOSS_COUNT  = 2,
  localparam int CW         = clog2(RATIO)
) (
  input  logic          sysClock,
  input  logic          reset,
  input  logic          pixelClockIn,
  input  logic [CW-1:0] phaseSel,
  output logic          pixelClockX1_en,
  output logic [CW-1:0] currentPhase,
  output logic          locked,
  output logic          edgeError,
  output logic [7:0]    errorCount
);

  if (!ratio_ok(RATIO) || !sync_stages_ok(SYNC_STAGES) ||
      !lock_count_ok(LOCK_COUNT) || !loss_count_ok(LOSS_COUNT)) begin : g_param_check
    $error("pixel_phase_tracker: parameter out of legal range");
  end

  localparam logic [CW-1:0] LAST_PHASE = CW'(RATIO - 1);

  track_state_e  state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [CW-1:0] sel_q, sel_d, sel_clamped;
  logic [7:0]    good_q, good_d;
  logic [3:0]    bad_q, bad_d;
  logic [7:0]    ecnt_q, ecnt_d;
  logic          en_q, en_d;
  logic          err_q, err_d;
  logic          prev_q;
  logic          pix_sync;
  logic          rise, at_last, aligned, misaligned, missing;

  bit_synchroniser #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(sysClock),
    .rst_i(reset),
    .d_i  (pixelClockIn),
    .q_o  (pix_sync)
  );

  assign rise       = pix_sync & ~prev_q;
  assign at_last    = (phase_q == LAST_PHASE);
  assign aligned    = rise & at_last;
  assign misaligned = rise & ~at_last;
  assign missing    = ~rise & at_last;

  assign sel_clamped = (phaseSel > LAST_PHASE) ? LAST_PHASE : phaseSel;

  always_comb begin
    state_d = state_q;
    phase_d = at_last ? '0 : phase_q + CW'(1);
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    ecnt_d  = ecnt_q;
    unique case (state_q)
      SEARCH: begin
        if (rise) begin
          phase_d = '0;
          good_d  = '0;
          state_d = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (aligned) begin
          good_d = good_q + 8'd1;
          if (good_q + 8'd1 == 8'(LOCK_COUNT)) begin
            state_d = LOCKED;
            bad_d   = '0;
          end
        end else if (misaligned) begin
          phase_d = '0;
          good_d  = '0;
        end else if (missing) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        // Flywheel: the counter free-runs here, edges only grade the period.
        if (aligned) begin
          bad_d = '0;
        end else if (misaligned || missing) begin
          err_d = 1'b1;
          bad_d = bad_q + 4'd1;
          if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
          if (bad_q + 4'd1 == 4'(LOSS_COUNT)) state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
    // Selection only moves at the period boundary so a period never sees two pulses.
    sel_d = at_last ? sel_clamped : sel_q;
    en_d  = (phase_d == sel_d);
  end

  always_ff @(posedge sysClock) begin
    if (reset) begin
      state_q <= SEARCH;
      phase_q <= '0;
      sel_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      ecnt_q  <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sel_q   <= sel_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      ecnt_q  <= ecnt_d;
      en_q    <= en_d;
      err_q   <= err_d;
      prev_q  <= pix_sync;
    end
  end

  assign pixelClockX1_en = en_q;
  assign currentPhase    = phase_q;
  assign locked          = (state_q == LOCKED);
  assign edgeError       = err_q;
  assign errorCount      = ecnt_q;

endmodule

// File: tb/tb_pixel_phase_tracker.sv
// Randomised bench for pixel_phase_tracker, checked cycle by cycle against a
// behavioural model plus scenario-level expectations.
module tb_pixel_phase_tracker;

  localparam int R     = 6;
  localparam int S     = 2;
  localparam int LOCKN = 8;
  localparam int LOSSN = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix = 1'b0;
  logic [2:0] sel_in = 3'd0;
  logic       en_o, locked_o, err_o;
  logic [2:0] phase_o;
  logic [7:0] ecnt_o;

  always #5 clk = ~clk;

  pixel_phase_tracker #(
    .RATIO(R), .SYNC_STAGES(S), .LOCK_COUNT(LOCKN), .LOSS_COUNT(LOSSN)
  ) dut (
    .sysClock       (clk),
    .reset          (rst),
    .pixelClockIn   (pix),
    .phaseSel       (sel_in),
    .pixelClockX1_en(en_o),
    .currentPhase   (phase_o),
    .locked         (locked_o),
    .edgeError      (err_o),
    .errorCount     (ecnt_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pixel levels seen at each edge, and the tracker's
  // abstract state (0 search, 1 acquire, 2 locked).
  logic hist[S+1];
  int m_st, m_ph, m_good, m_bad, m_sel, m_en, m_err, m_ecnt;

  task automatic model_edge();
    bit rise, last;
    int nph, nsel;
    if (rst) begin
      for (int i = 0; i <= S; i++) hist[i] = 1'b0;
      m_st = 0; m_ph = 0; m_good = 0; m_bad = 0;
      m_sel = 0; m_en = 0; m_err = 0; m_ecnt = 0;
      return;
    end
    rise = hist[S-1] && !hist[S];
    for (int i = S; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pix;
    last  = (m_ph == R - 1);
    nph   = (m_ph + 1) % R;
    m_err = 0;
    if (m_st == 0) begin
      if (rise) begin nph = 0; m_good = 0; m_st = 1; end
    end else if (m_st == 1) begin
      if (rise && last) begin
        m_good++;
        if (m_good == LOCKN) begin m_st = 2; m_bad = 0; end
      end else if (rise) begin
        nph = 0; m_good = 0;
      end else if (last) begin
        m_st = 0;
      end
    end else begin
      if (rise && last) m_bad = 0;
      else if (rise || last) begin
        m_err = 1;
        m_bad++;
        if (m_ecnt < 255) m_ecnt++;
        if (m_bad == LOSSN) m_st = 0;
      end
    end
    nsel = m_sel;
    if (last) nsel = (int'(sel_in) > R - 1) ? R - 1 : int'(sel_in);
    m_ph  = nph;
    m_sel = nsel;
    m_en  = (m_ph == m_sel);
  endtask

  // Pixel clock generator: 3 high / 3 low, with whole-period edge deletion.
  int pc = 0;
  int del_cnt = 0;
  bit in_del = 0;

  task automatic step();
    if (pc % R == 0) begin
      in_del = (del_cnt > 0);
      if (del_cnt > 0) del_cnt--;
    end
    pix = !in_del && ((pc % R) < 3);
    pc++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("en",     int'(en_o),     m_en);
    check("phase",  int'(phase_o),  m_ph);
    check("locked", int'(locked_o), (m_st == 2) ? 1 : 0);
    check("edgeErr", int'(err_o),   m_err);
    check("errCnt", int'(ecnt_o),   m_ecnt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Counts pulses per observed period, starting from the first phase-0 cycle.
  task automatic run_periods(input int n, input bit rand_sel);
    int cnt;
    bit started;
    cnt = 0; started = 0;
    for (int i = 0; i < n; i++) begin
      if (rand_sel && $urandom_range(0, 7) == 0) sel_in = 3'($urandom_range(0, 7));
      step();
      if (phase_o == 3'd0) begin
        if (started) check("pulses_per_period", cnt, 1);
        cnt = 0;
        started = 1;
      end
      cnt += int'(en_o);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(3);
    check("rst_en",     int'(en_o),     0);
    check("rst_phase",  int'(phase_o),  0);
    check("rst_locked", int'(locked_o), 0);
    check("rst_ecnt",   int'(ecnt_o),   0);
    rst = 1'b0;
  endtask

  int e0, lock_at, n;
  bit seen;

  initial begin
    for (int i = 0; i <= S; i++) hist[i] = 1'b0;
    pc = $urandom_range(0, R - 1);
    do_reset();

    // Lock acquisition from an arbitrary start phase.
    lock_at = -1;
    for (int i = 0; i < 80 && lock_at < 0; i++) begin
      step();
      if (locked_o) lock_at = i + 1;
    end
    check("lock_seen", (lock_at > 0) ? 1 : 0, 1);
    check("lock_within_10_periods", (lock_at > 0 && lock_at <= 10 * R) ? 1 : 0, 1);
    run_periods(36, 0);

    // Phase select 3 -> 5 mid-period, then 7 clamps to 5, then random.
    sel_in = 3'd3;
    run_periods(14, 0);
    while (phase_o != 3'd2) step();
    sel_in = 3'd5;
    run_periods(20, 0);
    sel_in = 3'd7;
    run(7);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (en_o) begin check("sel7_as_5", int'(phase_o), 5); seen = 1; end
    end
    check("sel7_pulse_seen", int'(seen), 1);
    run_periods(120, 1);

    // Flywheel over one deleted edge.
    e0 = int'(ecnt_o);
    del_cnt = 1;
    run(18);
    check("flywheel_ecnt", int'(ecnt_o), e0 + 1);
    check("flywheel_locked", int'(locked_o), 1);

    // Two deleted edges lose lock; clean edges reacquire.
    del_cnt = 2;
    run(24);
    check("loss_locked", int'(locked_o), 0);
    run(70);
    check("relock", int'(locked_o), 1);

    // Phase step during acquisition restarts the good count.
    do_reset();
    n = 0;
    while (m_st != 1 && n < 40) begin step(); n++; end
    check("reach_acquire", m_st, 1);
    run(14);
    pc += 2;
    lock_at = -1;
    for (int i = 0; i < 100 && lock_at < 0; i++) begin
      step();
      if (locked_o) lock_at = i + 1;
    end
    check("step_acq_relock_delay", (lock_at >= LOCKN * R && lock_at <= 70) ? 1 : 0, 1);

    // Same step while locked: errors until loss of lock.
    run(12);
    e0 = int'(ecnt_o);
    pc += 2;
    run(24);
    check("step_locked_lost", int'(locked_o), 0);
    check("step_locked_ecnt", int'(ecnt_o), e0 + 2);

    // Saturate errorCount with isolated deleted edges while staying locked.
    run(70);
    check("sat_prelock", int'(locked_o), 1);
    for (int k = 0; k < 270; k++) begin
      del_cnt = 1;
      run(R * (2 + int'($urandom_range(0, 1))));
    end
    check("sat_ecnt", int'(ecnt_o), 255);
    check("sat_locked", int'(locked_o), 1);

    // Reset in LOCKED with a saturated counter.
    rst = 1'b1;
    step();
    check("midrst_en",     int'(en_o),     0);
    check("midrst_phase",  int'(phase_o),  0);
    check("midrst_locked", int'(locked_o), 0);
    check("midrst_err",    int'(err_o),    0);
    check("midrst_ecnt",   int'(ecnt_o),   0);
    rst = 1'b0;
    run(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
